// File: rtl/cpu_multicycle.sv
// cpu_multicycle: parametrised multicycle CPU core with 16-bit instructions,
// a 16-entry register file (R0 reads as zero), Z/C flags, and separate
// instruction/data ports that use req/ack handshakes with wait states.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   imem_req    instruction fetch request (held until imem_ack)
//   imem_addr   fetch address (= PC)
//   imem_ack    instruction valid this cycle
//   imem_rdata  instruction word
//   dmem_req    data access request (held until dmem_ack)
//   dmem_we     1 = store, 0 = load
//   dmem_addr   data address
//   dmem_wdata  store data
//   dmem_ack    access complete, load data valid this cycle
//   dmem_rdata  load data
//   retire      one-cycle pulse per completed instruction
//   halted      core stopped by HALT until reset
module cpu_multicycle #(
   parameter int              DW       = 16,
   parameter int              AW       = 16,
   parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [15:0]   imem_rdata,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_ack,
   input  logic [DW-1:0] dmem_rdata,
   output logic          retire,
   output logic          halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic [15:0]   ir;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic [DW-1:0] rdv;       // old R[rd], needed by LSI
   logic [AW-1:0] target;
   logic          jump;
   logic          wr_en;
   logic [DW-1:0] res;
   logic          res_z;
   logic          res_c;
   logic          flag_z;
   logic          flag_c;
   logic [DW-1:0] regs [0:15];

   logic [3:0]    op;
   logic [3:0]    rd;
   logic [AW-1:0] pc_inc;
   logic [DW-1:0] alu_res;
   logic          alu_c;

   assign op        = ir[15:12];
   assign rd        = ir[11:8];
   assign pc_inc    = pc + {{(AW-1){1'b0}}, 1'b1};
   assign imem_addr = pc;

   function automatic logic [DW-1:0] rf_read(input logic [3:0] idx);
      return (idx == 4'h0) ? {DW{1'b0}} : regs[idx];
   endfunction

   // Result of the EXEC stage for every register-writing opcode.
   always_comb begin
      alu_res = {DW{1'b0}};
      alu_c   = 1'b0;
      case (op)
         4'h0: {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
         4'h1: begin
            alu_res = opa - opb;
            alu_c   = (opa < opb);
         end
         // A shift amount of DW or more already yields zero here.
         4'h2: alu_res = opa >> opb;
         4'h3: alu_res = opa << opb;
         4'h4: alu_res = opa | opb;
         4'h5: alu_res = opa & opb;
         4'h6: alu_res = ~opa;
         4'h7: alu_res = opa ^ opb;
         4'h8: alu_res = DW'(pc_inc);
         4'hC: alu_res = DW'(ir[7:0]);
         4'hD: alu_res = {rdv[DW-9:0], ir[7:0]};
         default: alu_res = {DW{1'b0}};
      endcase
   end

   // Control FSM, datapath registers, register file and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= 16'h0000;
         opa        <= {DW{1'b0}};
         opb        <= {DW{1'b0}};
         rdv        <= {DW{1'b0}};
         target     <= {AW{1'b0}};
         jump       <= 1'b0;
         wr_en      <= 1'b0;
         res        <= {DW{1'b0}};
         res_z      <= 1'b0;
         res_c      <= 1'b0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= {AW{1'b0}};
         dmem_wdata <= {DW{1'b0}};
         retire     <= 1'b0;
         halted     <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            regs[i] <= {DW{1'b0}};
         end
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               // First cycle after reset arrives here with req low.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  // HALT retires while it sits in DECODE.
                  retire   <= (imem_rdata[15:12] == 4'hF);
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               opa    <= rf_read(ir[7:4]);
               opb    <= rf_read(ir[3:0]);
               rdv    <= rf_read(rd);
               target <= rf_read(ir[3:0])[AW-1:0];
               case (op)
                  4'h8:    jump <= 1'b1;
                  4'h9:    jump <= flag_z;
                  4'hE:    jump <= flag_c;
                  default: jump <= 1'b0;
               endcase
               wr_en <= (op <= 4'h8) || (op == 4'hB) || (op == 4'hC) || (op == 4'hD);
               if (op == 4'hF) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               res   <= alu_res;
               res_z <= (alu_res == {DW{1'b0}});
               res_c <= alu_c;
               if ((op == 4'hA) || (op == 4'hB)) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= (op == 4'hA);
                  dmem_addr  <= opb[AW-1:0];
                  dmem_wdata <= opa;
                  state      <= S_MEM;
               end else begin
                  retire <= 1'b1;
                  state  <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_req && dmem_ack) begin
                  if (op == 4'hB) begin
                     res <= dmem_rdata;
                  end
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  retire   <= 1'b1;
                  state    <= S_WB;
               end
            end
            S_WB: begin
               if (wr_en && (rd != 4'h0)) begin
                  regs[rd] <= res;
               end
               if (op < 4'h8) begin
                  flag_z <= res_z;
                  flag_c <= res_c;
               end
               pc       <= jump ? target : pc_inc;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: begin
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
            end
            default: begin
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               state    <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed bench for cpu_multicycle (DW=32, AW=16,
// RESET_PC=0x0002). A small program in a ROM model exercises ALU/flags,
// wide constants, memory with wait states, branches, R0, HALT and reset
// during a stalled fetch. Fetches, retires and data accesses are logged
// and compared against hand-computed expectations.
module tb_cpu_multicycle;
   localparam int            DW  = 32;
   localparam int            AW  = 16;
   localparam logic [AW-1:0] RPC = 16'h0002;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [15:0]   imem_rdata;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;
   logic          retire;
   logic          halted;

   cpu_multicycle #(.DW(DW), .AW(AW), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .retire(retire), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [15:0]   rom  [0:255];
   logic [DW-1:0] dram [0:255];
   int idelay = 0;
   int icnt = 0;
   int dcnt = 0;
   int cyc = 0;
   logic force_iack = 1'b0;
   logic force_dack = 1'b0;

   assign imem_rdata = rom[imem_addr[7:0]];
   assign dmem_rdata = dram[dmem_addr[7:0]];
   assign imem_ack   = force_iack | (imem_req & (icnt >= idelay));
   assign dmem_ack   = force_dack | (dmem_req & (dcnt == 3));

   // Cycle counter and wait-state counters of the memory models.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
   end

   logic [AW-1:0] fetch_log [$];
   int            retire_log [$];
   logic [AW-1:0] st_addr [$];
   logic [DW-1:0] st_data [$];
   int            acc_cycles [$];
   bit            acc_stable [$];
   bit            acc_we [$];
   logic          acc_open = 1'b0;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wd;
   logic          a_we;
   int            a_cyc = 0;
   logic          a_stable = 1'b0;

   // Bus monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (imem_req && imem_ack) fetch_log.push_back(imem_addr);
      if (retire) retire_log.push_back(cyc);
      if (dmem_req) begin
         if (dmem_ack) begin
            acc_cycles.push_back(acc_open ? a_cyc + 1 : 1);
            acc_stable.push_back(acc_open ? (a_stable && dmem_addr == a_addr &&
                                 dmem_wdata == a_wd && dmem_we == a_we) : 1'b1);
            acc_we.push_back(dmem_we);
            if (dmem_we) begin
               st_addr.push_back(dmem_addr);
               st_data.push_back(dmem_wdata);
            end
            acc_open <= 1'b0;
         end else if (!acc_open) begin
            acc_open <= 1'b1;
            a_addr   <= dmem_addr;
            a_wd     <= dmem_wdata;
            a_we     <= dmem_we;
            a_cyc    <= 1;
            a_stable <= 1'b1;
         end else begin
            a_cyc <= a_cyc + 1;
            if (dmem_addr !== a_addr || dmem_wdata !== a_wd || dmem_we !== a_we) a_stable <= 1'b0;
         end
      end else begin
         acc_open <= 1'b0;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [AW-1:0] exp_fetch [0:30] = '{
      16'h02, 16'h03, 16'h04, 16'h05, 16'h06, 16'h07, 16'h08, 16'h09, 16'h0A, 16'h0B,
      16'h0C, 16'h20, 16'h21, 16'h22, 16'h23, 16'h24, 16'h30, 16'h31, 16'h32, 16'h33,
      16'h34, 16'h35, 16'h36, 16'h37, 16'h38, 16'h39, 16'h3A, 16'h3B, 16'h10, 16'h40, 16'h41};
   logic [DW-1:0] exp_st [0:6] = '{
      32'h0000_0100, 32'hFFFF_FF02, 32'h0000_0000, 32'h1234_5678,
      32'h0000_0000, 32'h0000_BEEF, 32'h0000_0011};

   initial begin
      int n;
      int base_f;
      int base_r;
      for (int i = 0; i < 256; i++) begin
         rom[i]  = 16'hF000;
         dram[i] = 32'h0;
      end
      dram[8'h40] = 32'h0000_BEEF;
      rom[8'h02] = 16'hC1FF; rom[8'h03] = 16'hC201; rom[8'h04] = 16'hC940;
      rom[8'h05] = 16'h0312; rom[8'h06] = 16'hA039; rom[8'h07] = 16'hCA20;
      rom[8'h08] = 16'hE00A; rom[8'h09] = 16'h900A; rom[8'h0A] = 16'h1421;
      rom[8'h0B] = 16'hA049; rom[8'h0C] = 16'hE00A;
      rom[8'h10] = 16'h8702;
      rom[8'h20] = 16'h7511; rom[8'h21] = 16'hA059; rom[8'h22] = 16'hCB30;
      rom[8'h23] = 16'hE00B; rom[8'h24] = 16'h900B;
      rom[8'h30] = 16'hC112; rom[8'h31] = 16'hD134; rom[8'h32] = 16'hD156;
      rom[8'h33] = 16'hD178; rom[8'h34] = 16'hA019; rom[8'h35] = 16'hC240;
      rom[8'h36] = 16'hC0AA; rom[8'h37] = 16'hA009; rom[8'h38] = 16'hB609;
      rom[8'h39] = 16'hA069; rom[8'h3A] = 16'hCC10; rom[8'h3B] = 16'h900C;
      rom[8'h40] = 16'hA079; rom[8'h41] = 16'hF000;

      // Reset held for three cycles, then released.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_halted", halted, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("first_imem_req", imem_req, 1'b1);
      chk("first_imem_addr", imem_addr, RPC);
      chk("first_dmem_req", dmem_req, 1'b0);
      chk("first_dmem_we", dmem_we, 1'b0);
      chk("first_retire", retire, 1'b0);
      chk("first_halted", halted, 1'b0);

      n = 0;
      while (!halted && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("halt_reached", halted, 1'b1);

      chk("fetch_count", fetch_log.size(), 31);
      for (int i = 0; i < 31; i++)
         chk($sformatf("fetch%0d", i), (i < fetch_log.size()) ? fetch_log[i] : 16'hDEAD, exp_fetch[i]);
      chk("store_count", st_data.size(), 7);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("st_addr%0d", i), (i < st_addr.size()) ? st_addr[i] : 16'hDEAD, 16'h0040);
         chk($sformatf("st_data%0d", i), (i < st_data.size()) ? st_data[i] : 32'hDEAD, exp_st[i]);
      end
      chk("retire_count", retire_log.size(), 31);
      if (retire_log.size() == 31) begin
         chk("lat_ldi", retire_log[1] - retire_log[0], 4);
         chk("lat_st_wait", retire_log[4] - retire_log[3], 8);
         chk("lat_ld_wait", retire_log[24] - retire_log[23], 8);
         chk("lat_halt", retire_log[30] - retire_log[29], 2);
      end
      chk("acc_count", acc_cycles.size(), 8);
      if (acc_cycles.size() == 8) begin
         chk("st_req_cycles", acc_cycles[3], 4);
         chk("st_we", acc_we[3], 1'b1);
         chk("ld_req_cycles", acc_cycles[5], 4);
         chk("ld_we", acc_we[5], 1'b0);
         for (int i = 0; i < 8; i++) chk($sformatf("acc_stable%0d", i), acc_stable[i], 1'b1);
      end

      // Halted core ignores stray acks and issues no requests.
      force_iack = 1'b1;
      force_dack = 1'b1;
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (imem_req || dmem_req || retire) n++;
      end
      chk("halt_quiet", n, 0);
      chk("halt_stays", halted, 1'b1);
      force_iack = 1'b0;
      force_dack = 1'b0;

      // Restart, then reset during a stalled fetch.
      rst = 1'b0;
      @(posedge clk); #1;
      chk("halt_cleared", halted, 1'b0);
      rst = 1'b1;
      base_f = fetch_log.size();
      base_r = retire_log.size();
      n = 0;
      while (fetch_log.size() < base_f + 5 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      idelay = 100000;
      n = 0;
      while (!imem_req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, 16'h0007);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_drop_req", imem_req, 1'b0);
      rst = 1'b1;
      force_iack = 1'b1;
      @(posedge clk); #1;
      chk("late_ack_req", imem_req, 1'b1);
      chk("restart_addr", imem_addr, RPC);
      force_iack = 1'b0;
      idelay = 0;
      n = 0;
      while (retire_log.size() < base_r + 6 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("restart_retire", retire_log.size(), base_r + 6);
      chk("restart_fetch", (fetch_log.size() > base_f + 5) ? fetch_log[base_f + 5] : 16'hDEAD, RPC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multicycle CPU core. It is the next generation of the team's 4-stage 16-bit CPU and keeps the 16-bit instruction format and 16-entry register file. New in this generation:
- configurable data and address width;
- separate instruction and data ports with req/ack handshakes (wait states);
- carry flag, shift-in immediate, conditional-on-carry jump, HALT, and a retire pulse.

It sits between the program ROM and the data RAM or bus bridge.

## Interface
- DW, 16: datapath and register width, ≥16
- AW, 16: address width, ≤DW
- RESET_PC, 0: PC value loaded at reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  AW  fetch address (= PC)
- imem_ack  in  1  instruction valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  AW  data address
- dmem_wdata  out  DW  store data
- dmem_ack  in  1  access complete; load data valid this cycle
- dmem_rdata  in  DW  load data
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  core stopped by HALT

## Operation
- **Instruction fields:** op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0], imm8=[7:0].
- **Register operands:** A = R[ra], B = R[rb]. R0 always reads 0; writes to R0 are discarded.
- **ALU ops 0–7:** ADD, SUB, SHR, SHL, OR, AND, NOT (~A), XOR. Result goes to rd, mod 2^DW.
  - Shifts are logical. Amount = B; amount ≥ DW gives 0.
  - Z = (result == 0).
  - C = carry-out for ADD; C = borrow (A < B unsigned) for SUB; C = 0 for all other ALU ops.
  - Only ALU ops change Z and C.
- **8 JAL:** rd = zero-extended PC+1, then PC = B[AW-1:0].
- **9 JZ:** if Z, PC = B[AW-1:0]; no register write.
- **A ST:** mem[B] = A; no register write.
- **B LD:** rd = mem[B].
- **C LDI:** rd = zero-extended imm8.
- **D LSI:** rd = (R[rd] << 8) | imm8, truncated to DW. Lets software build wide constants.
- **E JC:** if C, PC = B[AW-1:0]; no register write.
- **F HALT:** enter HALT state. halted = 1 and all requests stay low until reset.
- **Next PC:** PC+1 mod 2^AW unless a jump is taken.
- **Address truncation:** data address = B[AW-1:0].
- **FSM states:** FETCH → DECODE → EXEC → (MEM if LD/ST) → WB → FETCH. HALT is terminal.
  - FETCH: imem_req = 1 and imem_addr = PC, held until imem_ack. The instruction is latched on the ack cycle.
  - DECODE: latch A, B, imm8, and the jump decision. The jump decision uses the flags as they stand in this cycle.
  - EXEC: compute ALU result and PC+1.
  - MEM: dmem_req = 1 with addr, we, and wdata held stable until dmem_ack. Load data is captured on the ack cycle.
  - WB: write rd, update PC and flags, retire = 1.
  - HALT opcode: DECODE → HALT directly; retire pulses once on that transition.
- **Reset values** (any state, including mid-handshake): PC = RESET_PC, state = FETCH, R1–R15 = 0, Z = C = 0, imem_req = dmem_req = dmem_we = 0, retire = 0, halted = 0. A pending access is abandoned; an ack arriving after reset is ignored.
- **Ignored acks:** imem_ack and dmem_ack are ignored while the matching req is low.

## Timing
- All outputs are registered or decoded from state; none depends combinationally on an ack.
- The earliest accepted imem_ack is in the cycle imem_req first rises.
- Latency with zero-wait acks:
  - ALU, jump, LDI, LSI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LD/ST: 5 cycles.
  - Each wait cycle adds 1.
- imem_req rises in the first cycle after the cycle rst is sampled high. The first fetch address is RESET_PC.
- retire is high only in the WB cycle, or in the DECODE cycle for HALT.
- Register and flag writes in WB are visible to DECODE of the next instruction; no bypass is needed.
- PC wraps from 2^AW−1 to 0.

## Test plan
- **Reset/fetch:** hold rst = 0 for 3 cycles, release. Check imem_addr = RESET_PC and imem_req = 1 on the next cycle, and that all other outputs keep their reset values.
- **ALU and flags:**
  - LDI R1,0xFF; LDI R2,0x01; ADD R3,R1,R2 → R3 = 0x0100, Z = 0, C = 0.
  - SUB R4,R2,R1 → R4 = 0xFF02, C = 1.
  - XOR R5,R1,R1 → R5 = 0, Z = 1, C = 0.
- **Wide constant (DW=32):** LDI R1,0x12; LSI R1,0x34; LSI R1,0x56; LSI R1,0x78 → R1 = 0x12345678.
- **Memory with waits:** ST R1→[R2=0x40] with dmem_ack delayed 3 cycles. Check addr, wdata, and we held stable, req held 4 cycles, and retire once. Then LD R6←[0x40] returning 0xBEEF → R6 = 0xBEEF, 8 cycles total.
- **Branches:**
  - JZ taken after Z = 1 → PC = B; not taken → PC+1.
  - JAL R7,R2 at PC 0x10 → R7 = 0x11, PC = 0x40.
  - Writes to R0 leave R0 reading 0.
- **HALT and reset mid-operation:**
  - HALT → halted = 1 and no further imem_req.
  - Assert rst during a stalled fetch → req drops the next cycle, a late ack is ignored, and the restart fetches RESET_PC.
